tank_access: RTL and testbench

TANK_ACCESS -- requirements
Module: tank_access

---
 rtl/tank_access.sv | 142 ++++++++++++++
 tb/tb_tank_access.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_access.sv
`default_nettype none
// ============================================================================
// Module  : tank_access
// Purpose : Serial delay-line (tank) controller: recirculates the line and
//           performs single-slot read / read-before-write transfers.
// Revision: 1.0
// ============================================================================
module tank_access #(
  parameter int WORD_BITS = 18,
  parameter int WORDS     = 32,
  parameter int ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tank_out,
  output logic                 tank_in,
  input  logic                 req,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] rdata,
  output logic                 ack,
  output logic                 busy
);

  localparam int                  c_bit_w     = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(WORD_BITS - 1);
  localparam logic [ADDR_W-1:0]   c_last_word = ADDR_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_bit_w-1:0]     r_bit_cnt;
  logic [ADDR_W-1:0]      r_word_cnt;
  logic                   r_tank_in;
  logic [WORD_BITS-1:0]   r_rdata;
  logic                   r_we_q;
  logic [ADDR_W-1:0]      r_addr_q;
  logic [WORD_BITS-1:0]   r_wdata_q;
  logic                   w_proc;
  logic                   w_slot_start;
  logic                   w_last_bit;

  assign w_last_bit   = (r_bit_cnt == c_last_bit);
  assign w_slot_start = (r_word_cnt == r_addr_q) && (r_bit_cnt == '0);

  // w_proc marks a cycle in which the current tank bit belongs to the target slot
  always_comb begin
    w_state_nxt = r_state;
    w_proc      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_slot_start) begin
          w_proc      = 1'b1;
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        w_proc = 1'b1;
        if (w_last_bit) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Free-running slot position; it defines which slot is at tank_out each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
    end else begin
      if (w_last_bit) begin
        r_bit_cnt <= '0;
        if (r_word_cnt == c_last_word) begin
          r_word_cnt <= '0;
        end else begin
          r_word_cnt <= r_word_cnt + ADDR_W'(1);
        end
      end else begin
        r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we_q    <= 1'b0;
      r_addr_q  <= '0;
      r_wdata_q <= '0;
    end else if ((r_state == S_IDLE) && req) begin
      r_we_q    <= we;
      r_addr_q  <= addr;
      r_wdata_q <= wdata;
    end
  end

  // The old bit is always captured, so a write also returns the previous word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tank_in <= 1'b0;
      r_rdata   <= '0;
    end else if (w_proc) begin
      r_rdata[r_bit_cnt] <= tank_out;
      r_tank_in          <= r_we_q ? r_wdata_q[r_bit_cnt] : tank_out;
    end else begin
      r_tank_in <= tank_out;
    end
  end

  assign tank_in = r_tank_in;
  assign rdata   = r_rdata;
  assign ack     = (r_state == S_DONE);
  assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tank_access.sv
`default_nettype none
// ============================================================================
// Module  : tb_tank_access
// Purpose : Self-checking bench for tank_access with a behavioural delay line.
// Revision: 1.0
// ============================================================================
module tb_tank_access;

  localparam int WB   = 18;
  localparam int NW   = 32;
  localparam int AW   = 5;
  localparam int REV  = NW * WB;
  localparam int LINE = REV - 1;
  localparam int MAXLAT = REV + WB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tank_out;
  logic          tank_in;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [WB-1:0] wdata;
  logic [WB-1:0] rdata;
  logic          ack;
  logic          busy;

  tank_access #(.WORD_BITS(WB), .WORDS(NW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tank_out (tank_out),
    .tank_in  (tank_in),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // External delay line: the register inside the DUT plus LINE stages make one revolution
  logic [LINE-1:0] dl = '0;
  always @(posedge clk) dl <= {dl[LINE-2:0], tank_in};
  assign tank_out = dl[LINE-1];

  // Reference slot position (bit index within the revolution)
  int pos;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos <= 0;
    else        pos <= (pos == REV - 1) ? 0 : pos + 1;
  end

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [WB-1:0] d;
    logic [WB-1:0] e;
  } vec_t;

  vec_t          tbl [12];
  logic [WB-1:0] mem [NW];
  logic [WB-1:0] exp_q [$];
  int            n_chk = 0;
  int            n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req_v, $time);
    end
  endtask

  task automatic wait_pos(input int target);
    int guard = 0;
    while (pos != target && guard < 2 * REV) begin
      @(negedge clk);
      guard++;
    end
    check("wait_pos", pos, target);
  endtask

  // Called at the negedge after req was dropped; lat0 = cycles already elapsed
  task automatic wait_ack(input int lat0, output int lat);
    int            l = lat0;
    bit            drop = 1'b0;
    logic [WB-1:0] e;
    while (!ack && l < MAXLAT + 20) begin
      if (!busy) drop = 1'b1;
      @(negedge clk);
      l++;
    end
    check("busy_held", {31'd0, drop}, 32'd0);
    if (!ack) begin
      check("ack_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      check("sb_unexpected_ack", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("rdata", {14'd0, rdata}, {14'd0, e});
    end
    check("lat_range", {31'd0, (l >= WB + 1 && l <= MAXLAT)}, 32'd1);
    // A request presented during DONE must be dropped
    req   = 1'b1;
    we    = 1'($urandom);
    addr  = AW'($urandom);
    wdata = WB'($urandom);
    @(negedge clk);
    req = 1'b0;
    check("ack_pulse", {31'd0, ack}, 32'd0);
    check("done_req_ignored", {31'd0, busy}, 32'd0);
    lat = l;
  endtask

  // Called at a negedge with the DUT idle
  task automatic do_access(input logic w, input logic [AW-1:0] a, input logic [WB-1:0] d,
                           input logic [WB-1:0] e, output int lat);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    exp_q.push_back(e);
    if (w) mem[a] = d;
    @(negedge clk);
    req   = 1'b0;
    we    = 1'($urandom);
    addr  = AW'($urandom);
    wdata = WB'($urandom);
    wait_ack(1, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acks;
    int extra_busy;

    tbl[0]  = '{1'b1, 5'd3,  18'h2A5B5, 18'h00000};
    tbl[1]  = '{1'b0, 5'd3,  18'h3FFFF, 18'h2A5B5};
    tbl[2]  = '{1'b1, 5'd7,  18'h3FFFF, 18'h00000};
    tbl[3]  = '{1'b1, 5'd7,  18'h00000, 18'h3FFFF};
    tbl[4]  = '{1'b0, 5'd7,  18'h12345, 18'h00000};
    tbl[5]  = '{1'b0, 5'd2,  18'h00000, 18'h00000};
    tbl[6]  = '{1'b0, 5'd4,  18'h00000, 18'h00000};
    tbl[7]  = '{1'b1, 5'd31, 18'h15555, 18'h00000};
    tbl[8]  = '{1'b1, 5'd0,  18'h2AAAA, 18'h00000};
    tbl[9]  = '{1'b0, 5'd31, 18'h00000, 18'h15555};
    tbl[10] = '{1'b0, 5'd0,  18'h00000, 18'h2AAAA};
    tbl[11] = '{1'b0, 5'd3,  18'h00000, 18'h2A5B5};
    for (int i = 0; i < NW; i++) mem[i] = '0;

    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (4) @(negedge clk);
    check("rst_tank_in", {31'd0, tank_in}, 32'd0);
    check("rst_rdata",   {14'd0, rdata},   32'd0);
    check("rst_ack",     {31'd0, ack},     32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_access(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e, lat);
    end

    // Best case: accepted in the bit just before slot 5 starts
    wait_pos(5 * WB - 1);
    do_access(1'b0, 5'd5, 18'h0, mem[5], lat);
    check("lat_best", lat, WB + 1);
    // Worst case: accepted exactly as slot 5 bit 0 passes
    wait_pos(5 * WB);
    do_access(1'b1, 5'd5, 18'h00155, mem[5], lat);
    check("lat_worst", lat, MAXLAT);

    for (int i = 0; i < NW; i++) begin
      logic [WB-1:0] v;
      v = WB'(i * 18'h0111);
      do_access(1'b1, AW'(i), v, mem[i], lat);
    end
    for (int i = 0; i < NW; i++) begin
      do_access(1'b0, AW'(i), WB'($urandom), mem[i], lat);
    end

    // req held for three extra cycles while waiting
    wait_pos(12 * WB);
    req  = 1'b1;
    we   = 1'b0;
    addr = 5'd12;
    exp_q.push_back(mem[12]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("held_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    req = 1'b0;
    wait_ack(4, lat);
    acks = 0;
    extra_busy = 0;
    for (int k = 0; k < 40; k++) begin
      if (ack)  acks++;
      if (busy) extra_busy++;
      @(negedge clk);
    end
    check("held_extra_ack",  acks, 0);
    check("held_extra_busy", extra_busy, 0);

    // Reset in the middle of a write transfer
    wait_pos(10 * WB - 1);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 5'd10;
    wdata = 18'h3FFFF;
    @(negedge clk);
    req = 1'b0;
    repeat (6) @(negedge clk);
    check("xfer_busy_pre_rst", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack",     {31'd0, ack},     32'd0);
    check("mid_rst_busy",    {31'd0, busy},    32'd0);
    check("mid_rst_tank_in", {31'd0, tank_in}, 32'd0);
    check("mid_rst_rdata",   {14'd0, rdata},   32'd0);
    // Hold long enough for a full revolution of zeros to flush the line
    repeat (REV + 4) @(negedge clk);
    for (int i = 0; i < NW; i++) mem[i] = '0;
    rst_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ack || busy) acks++;
    end
    check("post_rst_idle", acks, 0);

    // Counters restarted from 0: best-case timing must hold again
    wait_pos(NW * WB - 1);
    do_access(1'b0, 5'd0, 18'h0, mem[0], lat);
    check("post_rst_lat_best", lat, WB + 1);
    do_access(1'b0, 5'd10, 18'h0, mem[10], lat);
    do_access(1'b1, 5'd9, 18'h2A5B5, mem[9], lat);
    do_access(1'b0, 5'd9, 18'h0, mem[9], lat);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
